// File: rtl/multi_channel_delay_buffer_pkg.sv
// Shared types and helpers for multi_channel_delay_buffer (lane type, warm-up states, delay clamp).
// Latency: none, this package holds declarations only.
// Backpressure: not applicable.
package multi_channel_delay_buffer_pkg;

  localparam int LANE_WIDTH = 16;

  typedef logic [LANE_WIDTH-1:0] lane_t;

  // FILL: buffer still warming up, output invalid. RUN: fill has reached the delay.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

  // Requested delay forced into the supported range 1..depth.
  function automatic int unsigned clamp_delay(input int unsigned cfg, input int unsigned depth);
    if (cfg == 0) return 1;
    if (cfg > depth) return depth;
    return cfg;
  endfunction

endpackage

// File: rtl/delay_buffer_ram.sv
// Simple dual-port storage for the delay line: one write port, one registered read port.
// Latency: read data valid one clock after a read-enabled edge; a read of the entry being written returns the old word.
// Backpressure: none, both ports accept an access on every enabled edge.
module delay_buffer_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 17
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; non-blocking update of mem_q gives read-before-write on collision.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_channel_delay_buffer.sv
// Runtime-configurable delay line for NUM_CH lanes plus valid; optional status ports via MULTI_CHANNEL_DELAY_BUFFER_STATUS_EN.
// Latency: the sample on the d-th enabled edge after restart leads, i.e. out after edge j = input taken at edge j-d+1.
// Backpressure: none; clk_en stalls the whole pipe, samples not consumed downstream are lost.
module multi_channel_delay_buffer
  import multi_channel_delay_buffer_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 1,
  parameter int DEPTH  = 512,
  parameter int DLY_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    clk_en,
  input  logic [DLY_W-1:0]        cfg_delay,
  input  logic                    valid_in,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic                    valid_out,
  output logic [NUM_CH*WIDTH-1:0] data_out
`ifdef MULTI_CHANNEL_DELAY_BUFFER_STATUS_EN
  ,
  output logic [DLY_W-1:0]        fill_level,
  output logic                    cfg_err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = NUM_CH * WIDTH + 1;

  logic [DLY_W-1:0] d_q, cfg_clamped;
  logic [AW-1:0]    wptr_q, wptr_d, raddr;
  logic [DLY_W-1:0] fill_q, fill_d;
  fill_state_e      state_q, state_d;
  logic             adv;
  logic [DW-1:0]    wr_word, wr_q, rd_word, src_word;
  logic             valid_out_q, valid_out_d;
  logic [DW-2:0]    data_out_q;
  logic [31:0]      rsum;

  assign cfg_clamped = DLY_W'(clamp_delay(32'(cfg_delay), DEPTH));
  assign adv         = clk_en & ~rst & ~flush;
  assign wr_word     = {valid_in, data_in};

  // Read address runs d-2 entries behind the write pointer so the registered RAM read
  // lands in the output register exactly when the sample is due.
  always_comb begin
    rsum = 32'(wptr_q) + 32'(DEPTH) + 32'd2 - 32'(d_q);
    if (rsum >= 32'(DEPTH)) rsum = rsum - 32'(DEPTH);
    if (rsum >= 32'(DEPTH)) rsum = rsum - 32'(DEPTH);
    raddr = AW'(rsum);
  end

  delay_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (adv),
    .waddr_i (wptr_q),
    .wdata_i (wr_word),
    .re_i    (adv),
    .raddr_i (raddr),
    .rdata_o (rd_word)
  );

  // Next pointer/fill/state and the output word; d=1 and d=2 bypass the RAM,
  // which cannot return a word written on the same or previous edge in time.
  always_comb begin
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    state_d     = state_q;
    src_word    = rd_word;
    valid_out_d = 1'b0;
    if (d_q == DLY_W'(1)) begin
      src_word = wr_word;
    end else if (d_q == DLY_W'(2)) begin
      src_word = wr_q;
    end
    if (rst || flush) begin
      wptr_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (clk_en) begin
      wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
      if (fill_q != d_q) fill_d = fill_q + DLY_W'(1);
      state_d = (fill_d == d_q) ? RUN : FILL;
    end
    valid_out_d = (state_d == RUN) && src_word[DW-1];
  end

  // Pointer, fill counter and warm-up state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
    end else begin
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      state_q <= state_d;
    end
  end

  // Active delay and output register; flush keeps data_out but drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= cfg_clamped;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else if (flush) begin
      d_q         <= cfg_clamped;
      valid_out_q <= 1'b0;
    end else if (clk_en) begin
      valid_out_q <= valid_out_d;
      data_out_q  <= src_word[DW-2:0];
    end
  end

  // Last written word, feeding the d=2 bypass.
  always_ff @(posedge clk) begin
    if (adv) wr_q <= wr_word;
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

`ifdef MULTI_CHANNEL_DELAY_BUFFER_STATUS_EN
  logic cfg_err_q;

  // Remember whether the delay captured at the last restart had to be clamped.
  always_ff @(posedge clk) begin
    if (rst || flush) cfg_err_q <= (cfg_delay == '0) || (32'(cfg_delay) > 32'(DEPTH));
  end

  assign fill_level = fill_q;
  assign cfg_err    = cfg_err_q;
`endif

endmodule
